// File: rtl/plic_mem.sv
// Single-source (PS/2, ID 10) PLIC register block with byte-wide access and a supervisor context.
// Defining PLIC_M_CONTEXT_EN adds a machine context sharing the source's in_service and masked state.
module plic_mem (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_data,
  input  logic [31:0] i_address,
  input  logic        i_write,
  input  logic        i_request,
  output logic [7:0]  o_data,
  output logic        o_data_DV,
  input  logic        i_ps2_interrupt,
  input  logic        i_ack,
  output logic        o_interrupt
);

  localparam logic [7:0]  SRC_ID = 8'd10;

  // Word addresses (byte offset >> 2) of the implemented registers.
  localparam logic [21:0] W_PRIO = 22'h00000A;
  localparam logic [21:0] W_PEND = 22'h000400;
  localparam logic [21:0] W_SEN  = 22'h000820;
  localparam logic [21:0] W_STH  = 22'h080400;
  localparam logic [21:0] W_SCLM = 22'h080401;
`ifdef PLIC_M_CONTEXT_EN
  localparam logic [21:0] W_MEN  = 22'h000800;
  localparam logic [21:0] W_MTH  = 22'h080000;
  localparam logic [21:0] W_MCLM = 22'h080001;
`endif

  typedef enum logic [3:0] {
    SEL_NONE,
    SEL_PRIO,
    SEL_PEND,
    SEL_SEN,
    SEL_STH,
    SEL_SCLM,
    SEL_MEN,
    SEL_MTH,
    SEL_MCLM
  } sel_e;

  sel_e        sel;
  logic [21:0] word_addr;
  logic [1:0]  byte_sel;
  logic        byte0;
  logic        rd_access;
  logic        wr_access;

  logic [2:0]  prio;
  logic        pending;
  logic        s_en;
  logic [2:0]  s_thr;
  logic        in_service;
  logic        masked;

  logic        s_eligible;
  logic        m_eligible;
  logic        s_irq;
  logic        m_irq;
  logic        claim_take;
  logic        complete;
  logic [31:0] rd_word;
  logic [7:0]  rd_byte;

  logic        unused_addr_hi;
  assign unused_addr_hi = ^i_address[31:24];

  assign word_addr = i_address[23:2];
  assign byte_sel  = i_address[1:0];
  assign byte0     = (byte_sel == 2'd0);
  assign rd_access = i_request & ~i_write;
  assign wr_access = i_request & i_write;

  always_comb begin
    sel = SEL_NONE;
    case (word_addr)
      W_PRIO:  sel = SEL_PRIO;
      W_PEND:  sel = SEL_PEND;
      W_SEN:   sel = SEL_SEN;
      W_STH:   sel = SEL_STH;
      W_SCLM:  sel = SEL_SCLM;
`ifdef PLIC_M_CONTEXT_EN
      W_MEN:   sel = SEL_MEN;
      W_MTH:   sel = SEL_MTH;
      W_MCLM:  sel = SEL_MCLM;
`endif
      default: sel = SEL_NONE;
    endcase
  end

  assign s_eligible = pending & s_en & (prio > s_thr);
  assign s_irq      = s_eligible & ~in_service & ~masked;

`ifdef PLIC_M_CONTEXT_EN
  logic       m_en;
  logic [2:0] m_thr;

  assign m_eligible = pending & m_en & (prio > m_thr);
  assign m_irq      = m_eligible & ~in_service & ~masked;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m_en  <= 1'b0;
      m_thr <= '0;
    end else if (wr_access) begin
      if (sel == SEL_MEN && byte_sel == 2'd1) m_en  <= i_data[2];
      if (sel == SEL_MTH && byte0)            m_thr <= i_data[2:0];
    end
  end
`else
  assign m_eligible = 1'b0;
  assign m_irq      = 1'b0;
`endif

  // Only a byte-0 claim read that actually returns the ID has side effects.
  assign claim_take = rd_access & byte0 &
                      (((sel == SEL_SCLM) & s_eligible) | ((sel == SEL_MCLM) & m_eligible));
  assign complete   = wr_access & byte0 & ((sel == SEL_SCLM) | (sel == SEL_MCLM)) &
                      (i_data == SRC_ID) & in_service;

  always_comb begin
    rd_word = '0;
    case (sel)
      SEL_PRIO: rd_word = {29'd0, prio};
      SEL_PEND: rd_word = {21'd0, pending, 10'd0};
      SEL_SEN:  rd_word = {21'd0, s_en, 10'd0};
      SEL_STH:  rd_word = {29'd0, s_thr};
      SEL_SCLM: rd_word = {24'd0, (s_eligible ? SRC_ID : 8'd0)};
`ifdef PLIC_M_CONTEXT_EN
      SEL_MEN:  rd_word = {21'd0, m_en, 10'd0};
      SEL_MTH:  rd_word = {29'd0, m_thr};
      SEL_MCLM: rd_word = {24'd0, (m_eligible ? SRC_ID : 8'd0)};
`endif
      default:  rd_word = '0;
    endcase
  end

  always_comb begin
    rd_byte = '0;
    case (byte_sel)
      2'd0: rd_byte = rd_word[7:0];
      2'd1: rd_byte = rd_word[15:8];
      2'd2: rd_byte = rd_word[23:16];
      2'd3: rd_byte = rd_word[31:24];
      default: rd_byte = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_data_DV <= 1'b0;
      o_data    <= '0;
    end else begin
      o_data_DV <= i_request;
      o_data    <= rd_access ? rd_byte : 8'd0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prio  <= '0;
      s_en  <= 1'b0;
      s_thr <= '0;
    end else if (wr_access) begin
      if (sel == SEL_PRIO && byte0)           prio  <= i_data[2:0];
      if (sel == SEL_SEN && byte_sel == 2'd1) s_en  <= i_data[2];
      if (sel == SEL_STH && byte0)            s_thr <= i_data[2:0];
    end
  end

  // A new event wins over a coincident claim so the second event is not lost.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pending     <= 1'b0;
      in_service  <= 1'b0;
      masked      <= 1'b0;
      o_interrupt <= 1'b0;
    end else begin
      if (i_ps2_interrupt)  pending <= 1'b1;
      else if (claim_take)  pending <= 1'b0;

      if (claim_take)       in_service <= 1'b1;
      else if (complete)    in_service <= 1'b0;

      if (claim_take || complete) masked <= 1'b0;
      else if (i_ack)             masked <= 1'b1;

      o_interrupt <= s_irq | m_irq;
    end
  end

endmodule

// File: tb/tb_plic_mem.sv
// Directed bench for plic_mem: register map, claim/complete flow, masking and reset behaviour.
module tb_plic_mem;

  logic        clk;
  logic        rst_n;
  logic [7:0]  i_data;
  logic [31:0] i_address;
  logic        i_write;
  logic        i_request;
  logic [7:0]  o_data;
  logic        o_data_DV;
  logic        i_ps2;
  logic        i_ack;
  logic        o_interrupt;

  int unsigned checks;
  int unsigned failures;

  plic_mem dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_data          (i_data),
    .i_address       (i_address),
    .i_write         (i_write),
    .i_request       (i_request),
    .o_data          (o_data),
    .o_data_DV       (o_data_DV),
    .i_ps2_interrupt (i_ps2),
    .i_ack           (i_ack),
    .o_interrupt     (o_interrupt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic access(input logic [31:0] a, input logic w, input logic [7:0] d,
                        input logic ps2, input logic ack, output logic [7:0] rd);
    @(negedge clk);
    i_request = 1'b1; i_write = w; i_address = a; i_data = d; i_ps2 = ps2; i_ack = ack;
    @(negedge clk);
    i_request = 1'b0; i_write = 1'b0; i_ps2 = 1'b0; i_ack = 1'b0;
    check("data_dv", {31'd0, o_data_DV}, 32'd1);
    rd = o_data;
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    logic [7:0] rd;
    access(a, 1'b1, d, 1'b0, 1'b0, rd);
  endtask

  task automatic rdc(input string tag, input logic [31:0] a, input logic [7:0] exp);
    logic [7:0] rd;
    access(a, 1'b0, 8'h00, 1'b0, 1'b0, rd);
    check(tag, {24'd0, rd}, {24'd0, exp});
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic pulse_ps2();
    @(negedge clk); i_ps2 = 1'b1;
    @(negedge clk); i_ps2 = 1'b0;
  endtask

  task automatic pulse_ack();
    @(negedge clk); i_ack = 1'b1;
    @(negedge clk); i_ack = 1'b0;
  endtask

  task automatic irq(input string tag, input logic exp);
    check(tag, {31'd0, o_interrupt}, {31'd0, exp});
  endtask

  initial begin
    logic [7:0] rd;
    checks = 0; failures = 0;
    rst_n = 1'b1; i_data = '0; i_address = '0; i_write = 1'b0;
    i_request = 1'b0; i_ps2 = 1'b0; i_ack = 1'b0;

    // Reset values
    #1 rst_n = 1'b0;
    idle(2);
    check("rst_o_data", {24'd0, o_data}, 32'd0);
    check("rst_dv", {31'd0, o_data_DV}, 32'd0);
    irq("rst_irq", 1'b0);
    rst_n = 1'b1;

    rdc("claim_after_reset", 32'h0020_1004, 8'h00);
    irq("irq_after_reset", 1'b0);
    idle(1);
    check("dv_single_pulse", {31'd0, o_data_DV}, 32'd0);

    // Configuration and map checks
    wr(32'h0000_0028, 8'hFF);
    rdc("prio_3bit", 32'h0000_0028, 8'h07);
    wr(32'h0000_0028, 8'h01);
    wr(32'h0000_2080, 8'h00);
    wr(32'h0000_2081, 8'h04);
    wr(32'h0020_1000, 8'h00);
    rdc("prio_rb", 32'h0000_0028, 8'h01);
    rdc("prio_byte1", 32'h0000_0029, 8'h00);
    rdc("addr_hi_ignored", 32'hFF00_0028, 8'h01);
    rdc("sen_rb", 32'h0000_2081, 8'h04);
    wr(32'h0000_0100, 8'hFF);
    rdc("unmapped", 32'h0000_0100, 8'h00);
    wr(32'h0000_2001, 8'h04);
    rdc("m_enable_absent", 32'h0000_2001, 8'h00);

    // Back-to-back reads
    @(negedge clk);
    i_request = 1'b1; i_write = 1'b0; i_address = 32'h0000_0028;
    @(negedge clk);
    i_address = 32'h0000_2081;
    check("b2b_dv0", {31'd0, o_data_DV}, 32'd1);
    check("b2b_d0", {24'd0, o_data}, 32'h01);
    @(negedge clk);
    i_request = 1'b0;
    check("b2b_dv1", {31'd0, o_data_DV}, 32'd1);
    check("b2b_d1", {24'd0, o_data}, 32'h04);
    @(negedge clk);
    check("b2b_dv_end", {31'd0, o_data_DV}, 32'd0);

    // Event -> pending -> interrupt
    irq("irq_idle", 1'b0);
    pulse_ps2();
    rdc("pending_set", 32'h0000_1001, 8'h04);
    irq("irq_raised", 1'b1);
    wr(32'h0000_1001, 8'h00);
    rdc("pending_ro", 32'h0000_1001, 8'h04);

    // Claim
    rdc("claim_id", 32'h0020_1004, 8'h0A);
    rdc("claim_byte1", 32'h0020_1005, 8'h00);
    irq("irq_after_claim", 1'b0);
    rdc("pending_cleared", 32'h0000_1001, 8'h00);

    // Event while in service, wrong and correct completion
    pulse_ps2();
    rdc("pending_in_service", 32'h0000_1001, 8'h04);
    irq("irq_in_service", 1'b0);
    wr(32'h0020_1004, 8'h05);
    idle(1);
    irq("irq_bad_complete", 1'b0);
    wr(32'h0020_1004, 8'h0A);
    idle(1);
    irq("irq_reassert", 1'b1);

    // Threshold blocks
    wr(32'h0020_1000, 8'h01);
    idle(1);
    irq("irq_threshold", 1'b0);
    rdc("claim_threshold", 32'h0020_1004, 8'h00);
    rdc("pending_kept", 32'h0000_1001, 8'h04);
    wr(32'h0020_1000, 8'h00);
    idle(1);
    irq("irq_thr_lowered", 1'b1);

    // Ack masks; a stray completion does not unmask
    pulse_ack();
    idle(1);
    irq("irq_masked", 1'b0);
    wr(32'h0020_1004, 8'h0A);
    idle(1);
    irq("irq_masked_stray", 1'b0);

    // Claim coincident with a new event
    access(32'h0020_1004, 1'b0, 8'h00, 1'b1, 1'b0, rd);
    check("claim_coincident", {24'd0, rd}, 32'h0A);
    rdc("pending_coincident", 32'h0000_1001, 8'h04);
    irq("irq_coincident_svc", 1'b0);
    wr(32'h0020_1004, 8'h0A);
    idle(1);
    irq("irq_after_complete", 1'b1);

    // Claim coincident with ack leaves masked clear
    access(32'h0020_1004, 1'b0, 8'h00, 1'b0, 1'b1, rd);
    check("claim_with_ack", {24'd0, rd}, 32'h0A);
    rdc("pending_after_ack_claim", 32'h0000_1001, 8'h00);
    wr(32'h0020_1004, 8'h0A);
    pulse_ps2();
    idle(1);
    irq("irq_not_masked", 1'b1);

    // Reset with a request in flight
    @(negedge clk);
    i_request = 1'b1; i_write = 1'b0; i_address = 32'h0000_0028;
    #3 rst_n = 1'b0;
    @(negedge clk);
    i_request = 1'b0;
    check("rst_flight_dv", {31'd0, o_data_DV}, 32'd0);
    check("rst_flight_data", {24'd0, o_data}, 32'd0);
    irq("rst_flight_irq", 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_release_dv", {31'd0, o_data_DV}, 32'd0);
    rdc("prio_after_reset", 32'h0000_0028, 8'h00);
    rdc("sen_after_reset", 32'h0000_2081, 8'h00);
    rdc("pending_after_reset", 32'h0000_1001, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/plic_mem.md
PLIC_MEM -- requirements
Module: plic_mem

Interface
REQ-001 SHALL have no parameters; the register map is fixed (base decode done externally, local offset = i_address[23:0]).
REQ-002 i_clk  input  1  sole clock, all state on rising edge.
REQ-003 i_rst_n  input  1  asynchronous active-low reset.
REQ-004 i_data  input  8  write byte.
REQ-005 i_address  input  32  byte address; only [23:0] decoded.
REQ-006 i_write  input  1  1 = write, 0 = read; sampled with i_request.
REQ-007 i_request  input  1  one-cycle access strobe, one byte per strobe.
REQ-008 o_data  output  8  read byte, valid while o_data_DV = 1.
REQ-009 o_data_DV  output  1  one-cycle completion pulse, reads and writes.
REQ-010 i_ps2_interrupt  input  1  source event pulse, interrupt ID 10.
REQ-011 i_ack  input  1  one-cycle pulse, CPU has taken the trap.
REQ-012 o_interrupt  output  1  level interrupt request to the supervisor context.

Function
REQ-013 Every i_request SHALL produce o_data_DV exactly one cycle later; back-to-back requests SHALL each be answered.
REQ-014 Registers SHALL be 32-bit, little-endian, byte-accessible: byte k is at offset + k.
REQ-015 Map: 0x000028 priority[10] (bits 2:0); 0x001000 pending (bit 10, read-only); 0x002080 S-enable (bit 10); 0x201000 S-threshold (bits 2:0); 0x201004 S-claim/complete.
REQ-016 Unimplemented bits and unmapped offsets SHALL read 0 and ignore writes, still acknowledged.
REQ-017 A cycle with i_ps2_interrupt = 1 SHALL set pending.
REQ-018 eligible = pending & enable & (priority > threshold).
REQ-019 Claim byte 0 read SHALL return 10 if eligible, else 0; bytes 1-3 SHALL read 0 with no side effect.
REQ-020 A claim read returning 10 SHALL clear pending and set in_service.
REQ-021 Any write to claim byte 0 with value 10 SHALL clear in_service; other values SHALL be ignored.
REQ-022 A write of 10 to claim byte 0 while in_service = 0 SHALL be ignored.
REQ-023 o_interrupt SHALL be registered: eligible & ~in_service & ~masked.
REQ-024 i_ack SHALL set masked; a claim read returning 10 or a completion write SHALL clear masked.
REQ-025 If i_ps2_interrupt coincides with a claim read, the claim SHALL complete and pending SHALL remain 1.
REQ-026 If i_ack coincides with a claim read returning 10, masked SHALL end 0.
REQ-027 Further events while in_service = 1 SHALL set pending only; o_interrupt SHALL reassert after completion.

Reset
REQ-028 While i_rst_n = 0, all registers (priority, pending, enable, threshold, in_service, masked) SHALL be 0.
REQ-029 While i_rst_n = 0, o_data = 0x00, o_data_DV = 0 and o_interrupt = 0.
REQ-030 A request in flight when reset asserts SHALL be dropped, with no o_data_DV after release.

Configuration
REQ-031 With PLIC_M_CONTEXT_EN defined, SHALL add an M context: M-enable 0x002000, M-threshold 0x200000, M-claim 0x200004, each with the same semantics as its S counterpart.
REQ-032 With PLIC_M_CONTEXT_EN defined, o_interrupt SHALL be the OR of the S and M requests, and in_service SHALL be shared.
REQ-033 Without PLIC_M_CONTEXT_EN, those offsets SHALL read 0 and ignore writes.

Verification
REQ-034 Reset, then read 0x201004 -> o_data_DV one cycle later, o_data 0x00, o_interrupt 0.
REQ-035 Write 0x28 = 0x01, 0x2080 = 0x00, 0x2081 = 0x04 (bit 10), 0x201000 = 0x00; pulse i_ps2_interrupt -> pending byte 0x1001 reads 0x04; o_interrupt = 1 the next cycle.
REQ-036 From REQ-035, read 0x201004 -> 0x0A; o_interrupt drops; 0x1001 reads 0x00.
REQ-037 Then write 0x0A to 0x201004 and pulse i_ps2_interrupt -> o_interrupt reasserts.
REQ-038 Threshold 0x201000 = 0x01 with priority 1 and pending set -> o_interrupt 0; claim reads 0x00.
REQ-039 Pending and eligible, pulse i_ack -> o_interrupt 0 until claim; i_ps2_interrupt coincident with claim -> claim returns 0x0A, pending stays 1.
